// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry.
//
// Fetch side : the current pc is looked up combinationally. The result drives
//              the fetch-stage next-pc mux in the same cycle as pc.
// Execute side: a resolved branch or jump writes back through one update port.
//              The write can allocate an entry, retrain an entry, or leave the
//              table unchanged.
//
// Update port semantics: update_en is a single-cycle strobe with no
// backpressure. The table always accepts the update on the next rising edge.
// update_* are don't-care while update_en is low.
//
// Ports
//   clk                 in   1   rising-edge clock
//   rst                 in   1   asynchronous active-high reset
//   pc                  in   32  fetch pc to look up
//   btb_target_pc       out  32  predicted target on hit, else 0
//   btb_pc_valid        out  1   lookup hit (entry valid and tag match)
//   btb_pc_predictTaken out  1   hit and counter msb set
//   update_en           in   1   resolved control-flow instruction this cycle
//   update_pc           in   32  pc of the resolved instruction
//   update_target       in   32  resolved target address
//   update_taken        in   1   resolved direction (1 = taken)
// ---------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] btb_target_pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  // The word-offset bits of both addresses play no part in indexing or tagging.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], update_pc[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Fetch-side lookup. It reads only the registered table, so an update in
  // flight to the same index stays invisible until after the edge.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  always_comb begin
    lk_idx              = pc[IDX_W+1:2];
    lk_tag              = pc[31:IDX_W+2];
    lk_hit              = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    btb_pc_valid        = lk_hit;
    btb_pc_predictTaken = lk_hit && ctr_q[lk_idx][1];
    btb_target_pc       = lk_hit ? target_q[lk_idx] : 32'h0;
  end

  // -------------------------------------------------------------------------
  // Execute-side update: next-state for the whole table.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    up_idx = update_pc[IDX_W+1:2];
    up_tag = update_pc[31:IDX_W+2];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          ctr_d[up_idx]    = sat_inc(ctr_q[up_idx]);
          target_d[up_idx] = update_target;
        end else begin
          ctr_d[up_idx]    = sat_dec(ctr_q[up_idx]);
        end
      end else if (update_taken) begin
        // Allocation on a taken miss. A conflicting entry is simply replaced;
        // there is no replacement state to consult.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = CTR_ALLOC;
      end
      // A not-taken miss never allocates.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//
// Directed bench for branch_target_buffer (ENTRIES = 16).
// Inputs change 1 time unit after a rising edge. Outputs are compared a
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  int vectors;
  int miscompares;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .btb_target_pc       (btb_target_pc),
    .btb_pc_valid        (btb_pc_valid),
    .btb_pc_predictTaken (btb_pc_predictTaken),
    .update_en           (update_en),
    .update_pc           (update_pc),
    .update_target       (update_target),
    .update_taken        (update_taken)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Driver and checker tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic [31:0] tgt,
                           input logic tk);
    update_en     = 1'b1;
    update_pc     = a;
    update_target = tgt;
    update_taken  = tk;
    step();
    update_en     = 1'b0;
    update_pc     = 'x;
    update_target = 'x;
    update_taken  = 1'bx;
  endtask

  task automatic check_outputs(input string tag, input logic exp_v,
                               input logic exp_t, input logic [31:0] exp_tgt);
    vectors++;
    assert (btb_pc_valid === exp_v) else begin
      miscompares++;
      $error("FAIL %s valid: got %b expected %b", tag, btb_pc_valid, exp_v);
    end
    vectors++;
    assert (btb_pc_predictTaken === exp_t) else begin
      miscompares++;
      $error("FAIL %s predictTaken: got %b expected %b", tag,
             btb_pc_predictTaken, exp_t);
    end
    vectors++;
    assert (btb_target_pc === exp_tgt) else begin
      miscompares++;
      $error("FAIL %s target: got %h expected %h", tag, btb_target_pc, exp_tgt);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] a,
                        input logic exp_v, input logic exp_t,
                        input logic [31:0] exp_tgt);
    pc = a;
    #1;
    check_outputs(tag, exp_v, exp_t, exp_tgt);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    pc            = 32'h0;
    update_en     = 1'b0;
    update_pc     = 32'h0;
    update_target = 32'h0;
    update_taken  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // 1: empty table after reset
    lookup("rst_lookup_100", 32'h100, 1'b0, 1'b0, 32'h0);

    // 2: allocate on a taken miss, ctr = 10
    do_update(32'h100, 32'h200, 1'b1);
    lookup("alloc_100", 32'h100, 1'b1, 1'b1, 32'h200);
    lookup("offset_bits_ignored", 32'h103, 1'b1, 1'b1, 32'h200);

    // 3: train up to 11 and saturate there
    do_update(32'h100, 32'h200, 1'b1);
    do_update(32'h100, 32'h200, 1'b1);
    do_update(32'h100, 32'h200, 1'b1);
    do_update(32'h100, 32'h200, 1'b0);   // 11 -> 10
    lookup("nt1_ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 32'h200, 1'b0);   // 10 -> 01
    lookup("nt2_ctr01", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b0);   // 01 -> 00
    do_update(32'h100, 32'h200, 1'b0);   // holds 00
    do_update(32'h100, 32'h200, 1'b0);   // holds 00
    lookup("nt5_ctr00", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);   // 00 -> 01
    lookup("sat_low_then_t", 32'h100, 1'b1, 1'b0, 32'h200);
    do_update(32'h100, 32'h200, 1'b1);   // 01 -> 10
    lookup("sat_low_then_tt", 32'h100, 1'b1, 1'b1, 32'h200);

    // 4: a not-taken miss never allocates and leaves the resident entry alone
    do_update(32'h300, 32'h900, 1'b0);
    lookup("nt_miss_300", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("nt_miss_keeps_100", 32'h100, 1'b1, 1'b1, 32'h200);
    // Alias on index 0: a taken update at 0x140 evicts 0x100
    do_update(32'h140, 32'h880, 1'b1);
    lookup("alias_evicted_100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("alias_new_140", 32'h140, 1'b1, 1'b1, 32'h880);

    // 5: same-cycle lookup and update of the same index
    do_update(32'h100, 32'h200, 1'b1);   // reallocate, ctr 10
    lookup("realloc_100", 32'h100, 1'b1, 1'b1, 32'h200);
    update_en     = 1'b1;
    update_pc     = 32'h100;
    update_target = 32'h400;
    update_taken  = 1'b1;
    #1;
    check_outputs("same_cycle_old", 1'b1, 1'b1, 32'h200);
    step();
    update_en = 1'b0;
    #1;
    check_outputs("same_cycle_new", 1'b1, 1'b1, 32'h400);

    // 6: asynchronous reset mid-cycle while an update is pending
    step();
    pc            = 32'h100;
    update_en     = 1'b1;
    update_pc     = 32'h100;
    update_target = 32'h500;
    update_taken  = 1'b1;
    #1;
    check_outputs("pre_async_rst", 1'b1, 1'b1, 32'h400);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("async_rst_immediate", 1'b0, 1'b0, 32'h0);
    step();                              // edge with rst high and update_en=1
    check_outputs("rst_held_edge", 1'b0, 1'b0, 32'h0);
    update_en = 1'b0;
    #2;
    rst = 1'b0;
    step();
    lookup("post_rst_100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_140", 32'h140, 1'b0, 1'b0, 32'h0);

    // Update after reset: a fresh allocation sets ctr 10 and the target
    do_update(32'h2c, 32'h1234, 1'b1);
    lookup("post_rst_alloc", 32'h2c, 1'b1, 1'b1, 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
